// File: rtl/key_mode_ctrl.sv
// rtl/key_mode_ctrl.sv - push-button sync, debounce, press detect and one-hot mode FSM
module key_mode_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [3:0] key_in,
    output logic [3:0] key,
    output logic [3:0] key_pulse,
    output logic       mode_active
);

    localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [3:0] {
        NORMAL = 4'b0000,
        MAN0   = 4'b0001,
        MAN1   = 4'b0010,
        MAN2   = 4'b0100,
        MAN3   = 4'b1000
    } state_e;

    logic [3:0]  sync1_q, sync2_q;
    logic [3:0]  stable_q, stable_d, stable_prev_q;
    logic [19:0] cnt_q [4];
    logic [19:0] cnt_d [4];
    logic [3:0]  press;
    logic [3:0]  key_pulse_q;
    logic        mode_active_q;
    state_e      state_q, state_d;

    // Counter only runs while the synchronised level disagrees with the accepted one
    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 20'd1;
            end
        end
    end

    assign press = stable_prev_q & ~stable_q;

    // Lowest pressed index wins; pressing the active mode's key returns to NORMAL
    always_comb begin
        state_d = state_q;
        if (press[0]) begin
            state_d = (state_q == MAN0) ? NORMAL : MAN0;
        end else if (press[1]) begin
            state_d = (state_q == MAN1) ? NORMAL : MAN1;
        end else if (press[2]) begin
            state_d = (state_q == MAN2) ? NORMAL : MAN2;
        end else if (press[3]) begin
            state_d = (state_q == MAN3) ? NORMAL : MAN3;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1_q       <= 4'b1111;
            sync2_q       <= 4'b1111;
            stable_q      <= 4'b1111;
            stable_prev_q <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            key_pulse_q   <= 4'b0000;
            mode_active_q <= 1'b0;
            state_q       <= NORMAL;
        end else begin
            sync1_q       <= key_in;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            key_pulse_q   <= press;
            mode_active_q <= (state_d != NORMAL);
            state_q       <= state_d;
        end
    end

    assign key         = state_q;
    assign key_pulse   = key_pulse_q;
    assign mode_active = mode_active_q;

endmodule

// File: tb/tb_key_mode_ctrl.sv
// tb/tb_key_mode_ctrl.sv - directed table and sequence bench for key_mode_ctrl
module tb_key_mode_ctrl;

    localparam int D = 8;

    logic       sys_clk;
    logic       sys_rst;
    logic [3:0] key_in;
    logic [3:0] key;
    logic [3:0] key_pulse;
    logic       mode_active;

    int checks;
    int errors;

    key_mode_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .key_in      (key_in),
        .key         (key),
        .key_pulse   (key_pulse),
        .mode_active (mode_active)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [3:0] key_in;
        int         hold;
        int         exp_pulse_cnt;
        logic [3:0] exp_pulse_or;
        logic [3:0] exp_key;
    } vec_t;

    vec_t vecs[17];

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        cyc();
        check4("rst_key", key, 4'b0000);
        check4("rst_pulse", key_pulse, 4'b0000);
        check1("rst_mode", mode_active, 1'b0);
        sys_rst = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int         cnt;
        logic [3:0] orv;
        cnt = 0;
        orv = 4'b0000;
        key_in = v.key_in;
        repeat (v.hold) begin
            cyc();
            if (key_pulse != 4'b0000) cnt++;
            orv |= key_pulse;
        end
        checki($sformatf("vec%0d_pulse_cnt", idx), cnt, v.exp_pulse_cnt);
        check4($sformatf("vec%0d_pulse_bits", idx), orv, v.exp_pulse_or);
        check4($sformatf("vec%0d_key", idx), key, v.exp_key);
        check1($sformatf("vec%0d_mode", idx), mode_active, v.exp_key != 4'b0000);
    endtask

    initial begin
        int pcnt;
        checks = 0;
        errors = 0;

        vecs[0]  = '{4'b1011, 12, 1, 4'b0100, 4'b0100};
        vecs[1]  = '{4'b1111, 12, 0, 4'b0000, 4'b0100};
        vecs[2]  = '{4'b1011, 12, 1, 4'b0100, 4'b0000};
        vecs[3]  = '{4'b1111, 12, 0, 4'b0000, 4'b0000};
        vecs[4]  = '{4'b0111, 12, 1, 4'b1000, 4'b1000};
        vecs[5]  = '{4'b1111, 12, 0, 4'b0000, 4'b1000};
        vecs[6]  = '{4'b1110, 12, 1, 4'b0001, 4'b0001};
        vecs[7]  = '{4'b1111, 12, 0, 4'b0000, 4'b0001};
        vecs[8]  = '{4'b0101, 12, 1, 4'b1010, 4'b0010};
        vecs[9]  = '{4'b1111, 12, 0, 4'b0000, 4'b0010};
        vecs[10] = '{4'b0101, 12, 1, 4'b1010, 4'b0000};
        vecs[11] = '{4'b1111, 12, 0, 4'b0000, 4'b0000};
        vecs[12] = '{4'b1110, 7,  0, 4'b0000, 4'b0000};
        vecs[13] = '{4'b1111, 12, 0, 4'b0000, 4'b0000};
        vecs[14] = '{4'b1110, 8,  0, 4'b0000, 4'b0000};
        vecs[15] = '{4'b1111, 12, 1, 4'b0001, 4'b0001};
        vecs[16] = '{4'b1111, 12, 0, 4'b0000, 4'b0001};

        key_in  = 4'b1111;
        sys_rst = 1'b1;
        cyc();
        do_reset();

        // Clean press: pulse exactly at cycle 11, key held afterwards
        key_in = 4'b1110;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            check4($sformatf("clean_pulse_c%0d", c), key_pulse, (c == 11) ? 4'b0001 : 4'b0000);
            check4($sformatf("clean_key_c%0d", c), key, (c >= 11) ? 4'b0001 : 4'b0000);
            check1($sformatf("clean_mode_c%0d", c), mode_active, c >= 11);
        end
        key_in = 4'b1111;
        for (int c = 1; c <= 30; c++) begin
            cyc();
            check4($sformatf("release_pulse_c%0d", c), key_pulse, 4'b0000);
            check4($sformatf("release_key_c%0d", c), key, 4'b0001);
        end

        // Bounce rejection on key 1
        do_reset();
        for (int c = 0; c < 40; c++) begin
            key_in = (((c / 3) % 2) == 0) ? 4'b1101 : 4'b1111;
            cyc();
            check4($sformatf("bounce_pulse_c%0d", c), key_pulse, 4'b0000);
            check4($sformatf("bounce_key_c%0d", c), key, 4'b0000);
        end
        key_in = 4'b1111;
        repeat (12) begin
            cyc();
            check4("bounce_settle_pulse", key_pulse, 4'b0000);
        end
        key_in = 4'b1101;
        for (int c = 1; c <= 12; c++) begin
            cyc();
            check4($sformatf("bhold_pulse_c%0d", c), key_pulse, (c == 11) ? 4'b0010 : 4'b0000);
            check4($sformatf("bhold_key_c%0d", c), key, (c >= 11) ? 4'b0010 : 4'b0000);
        end
        key_in = 4'b1111;
        repeat (12) cyc();

        // Toggle, switch, simultaneous presses and glitch-length boundary
        do_reset();
        for (int i = 0; i < 17; i++) begin
            run_vec(i, vecs[i]);
        end

        // Long hold on key 0
        do_reset();
        key_in = 4'b1110;
        pcnt = 0;
        for (int c = 1; c <= 1000; c++) begin
            cyc();
            if (key_pulse != 4'b0000) pcnt++;
            if (c >= 11) begin
                check4($sformatf("long_key_c%0d", c), key, 4'b0001);
            end
        end
        checki("long_pulse_cnt", pcnt, 1);
        key_in = 4'b1111;
        repeat (12) cyc();
        check4("long_release_key", key, 4'b0001);

        // Reset mid-debounce with key 3 held through it
        key_in = 4'b0111;
        repeat (7) cyc();
        check4("middeb_key_before", key, 4'b0001);
        sys_rst = 1'b1;
        cyc();
        check4("middeb_rst_key", key, 4'b0000);
        check4("middeb_rst_pulse", key_pulse, 4'b0000);
        check1("middeb_rst_mode", mode_active, 1'b0);
        sys_rst = 1'b0;
        for (int c = 1; c <= 14; c++) begin
            cyc();
            check4($sformatf("middeb_pulse_c%0d", c), key_pulse, (c == 11) ? 4'b1000 : 4'b0000);
            check4($sformatf("middeb_key_c%0d", c), key, (c >= 11) ? 4'b1000 : 4'b0000);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
